// File: rtl/qsn_pkg.sv
// qsn_pkg: shared definitions for the 17-lane quasi-cyclic shift network
// sequencer.
//   P        circulant size
//   SHIFT_W  width of a shift factor and of the shifter controls
//   MERGE_W  width of the thermometer merge select
//   state_t  sequencer FSM states
//   decode_shift()  turns one shift factor into {left, right, merge} controls
package qsn_pkg;

  localparam int P       = 17;
  localparam int SHIFT_W = 5;
  localparam int MERGE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [SHIFT_W-1:0] left;
    logic [SHIFT_W-1:0] right;
    logic [MERGE_W-1:0] merge;
  } sel_t;

  // A factor outside the circulant (s >= P) is decoded as s = 0 so the
  // network still moves well-formed data; the caller flags the error.
  // Merge lane i takes the left shifter output while i < 16 - s.
  function automatic sel_t decode_shift(input logic [SHIFT_W-1:0] s);
    sel_t               d;
    logic [SHIFT_W-1:0] s_eff;
    s_eff   = (int'(s) >= P) ? '0 : s;
    d.left  = s_eff;
    d.right = SHIFT_W'(MERGE_W) - s_eff;
    d.merge = '0;
    for (int i = 0; i < MERGE_W; i++) begin
      d.merge[i] = (i < (MERGE_W - int'(s_eff)));
    end
    return d;
  endfunction

endpackage

// File: rtl/qsn_sel_delay.sv
// qsn_sel_delay: PIPE_DEPTH-stage valid+data shift register that keeps the
// merge select aligned with the shifter pipeline.
//   clk        rising-edge clock
//   rstn       synchronous active-low reset, clears every stage
//   in_sel     select entering the line
//   in_valid   in_sel is valid
//   out_sel    select delayed by PIPE_DEPTH cycles (a wire when 0)
//   out_valid  in_valid delayed alongside out_sel
module qsn_sel_delay
  import qsn_pkg::*;
#(
  parameter int PIPE_DEPTH = 1,
  parameter int W          = MERGE_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] in_sel,
  input  logic         in_valid,
  output logic [W-1:0] out_sel,
  output logic         out_valid
);

  generate
    if (PIPE_DEPTH == 0) begin : g_wire
      assign out_sel   = in_sel;
      assign out_valid = in_valid;
    end else begin : g_pipe
      logic [W-1:0]          sel_q [PIPE_DEPTH];
      logic [PIPE_DEPTH-1:0] valid_q;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int i = 0; i < PIPE_DEPTH; i++) begin
            sel_q[i] <= '0;
          end
          valid_q <= '0;
        end else begin
          sel_q[0]   <= in_sel;
          valid_q[0] <= in_valid;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            sel_q[i]   <= sel_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign out_sel   = sel_q[PIPE_DEPTH-1];
      assign out_valid = valid_q[PIPE_DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/qsn_ctrl_len17.sv
// qsn_ctrl_len17: per-layer sequencer for the 17-lane QSN. Walks the layer's
// columns, accepts one shift factor per cycle, registers the shifter
// controls and sends the thermometer merge select through a delay line.
//   sys_clk       clock
//   rstn          synchronous active-low reset
//   start         begin a layer (ignored while busy)
//   col_num       columns in the layer, sampled with start
//   shift_factor  circulant shift for the current column
//   shift_valid   shift_factor valid
//   shift_ready   factor accepted this cycle when valid
//   left_sel      left shifter amount       (valid with shf_valid)
//   right_sel     right shifter amount      (valid with shf_valid)
//   shf_valid     shifter controls valid
//   col_idx       column index of the shifter controls
//   merge_sel     thermometer merge select  (valid with merge_valid)
//   merge_valid   merge select valid
//   busy          layer in progress
//   layer_done    one-cycle pulse after the last merge select issued
//   factor_err    sticky: a factor >= P was seen, cleared by start
module qsn_ctrl_len17
  import qsn_pkg::*;
#(
  parameter int PIPE_DEPTH = 1,
  parameter int COL_MAX    = 32
) (
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [5:0]         col_num,
  input  logic [SHIFT_W-1:0] shift_factor,
  input  logic               shift_valid,
  output logic               shift_ready,
  output logic [SHIFT_W-1:0] left_sel,
  output logic [SHIFT_W-1:0] right_sel,
  output logic               shf_valid,
  output logic [MERGE_W-1:0] merge_sel,
  output logic               merge_valid,
  output logic [4:0]         col_idx,
  output logic               busy,
  output logic               layer_done,
  output logic               factor_err
);

  state_t             state;
  logic [5:0]         col_len;
  logic [5:0]         col_cnt;
  logic [1:0]         drain_cnt;
  logic [MERGE_W-1:0] merge_raw;
  logic               merge_raw_valid;
  logic               accept;
  sel_t               dec;

  assign accept = shift_valid & shift_ready;
  assign dec    = decode_shift(shift_factor);

  // Sequencer FSM. All outputs are registered here; shift_ready and busy are
  // set together with the state so they are valid the cycle the state is.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      col_len         <= '0;
      col_cnt         <= '0;
      drain_cnt       <= '0;
      shift_ready     <= 1'b0;
      busy            <= 1'b0;
      layer_done      <= 1'b0;
      factor_err      <= 1'b0;
      left_sel        <= '0;
      right_sel       <= '0;
      col_idx         <= '0;
      shf_valid       <= 1'b0;
      merge_raw       <= '0;
      merge_raw_valid <= 1'b0;
    end else begin
      layer_done      <= 1'b0;
      shf_valid       <= 1'b0;
      merge_raw_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            factor_err <= 1'b0;
            if (col_num == 6'd0) begin
              layer_done <= 1'b1;
            end else begin
              col_len     <= (col_num > 6'(COL_MAX)) ? 6'(COL_MAX) : col_num;
              col_cnt     <= '0;
              state       <= ST_RUN;
              shift_ready <= 1'b1;
              busy        <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            left_sel        <= dec.left;
            right_sel       <= dec.right;
            merge_raw       <= dec.merge;
            shf_valid       <= 1'b1;
            merge_raw_valid <= 1'b1;
            col_idx         <= col_cnt[4:0];
            col_cnt         <= col_cnt + 6'd1;
            if (int'(shift_factor) >= P) begin
              factor_err <= 1'b1;
            end
            if (col_cnt == col_len - 6'd1) begin
              state       <= ST_DRAIN;
              shift_ready <= 1'b0;
              drain_cnt   <= '0;
            end
          end
        end
        ST_DRAIN: begin
          // PIPE_DEPTH+1 cycles here lets the final select leave the line
          // before layer_done, which lands in the first IDLE cycle.
          if (drain_cnt == 2'(PIPE_DEPTH)) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            layer_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          shift_ready <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  qsn_sel_delay #(
    .PIPE_DEPTH(PIPE_DEPTH),
    .W         (MERGE_W)
  ) u_sel_delay (
    .clk      (sys_clk),
    .rstn     (rstn),
    .in_sel   (merge_raw),
    .in_valid (merge_raw_valid),
    .out_sel  (merge_sel),
    .out_valid(merge_valid)
  );

endmodule

// File: tb/tb_qsn_ctrl_len17.sv
// tb_qsn_ctrl_len17: three sequencer instances (PIPE_DEPTH 0, 1, 3) share one
// stimulus stream; a transaction-level model predicts each one's outputs.
module tb_qsn_ctrl_len17;

  localparam int NCYC = 4096;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [5:0] col_num;
  logic [4:0] shift_factor;
  logic       shift_valid;

  logic [2:0]  ready_v, shf_v, mv_v, busy_v, done_v, err_v;
  logic [4:0]  left_v  [3];
  logic [4:0]  right_v [3];
  logic [4:0]  idx_v   [3];
  logic [15:0] merge_v [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected timeline per instance, indexed by cycle
  logic        e_shf   [3][NCYC];
  logic [4:0]  e_left  [3][NCYC];
  logic [4:0]  e_right [3][NCYC];
  logic [4:0]  e_idx   [3][NCYC];
  logic        e_mv    [3][NCYC];
  logic [15:0] e_merge [3][NCYC];
  logic        e_done  [3][NCYC];

  // Layer-level model state per instance
  bit m_in_layer [3];
  int m_cols_left[3];
  int m_next_idx [3];
  int m_done_cyc [3];
  bit m_err      [3];

  typedef struct {
    logic        st;
    logic [5:0]  cn;
    logic        sv;
    logic [4:0]  sf;
    logic        e_ready;
    logic        e_busy;
    logic        e_shf;
    logic [4:0]  e_left;
    logic [4:0]  e_right;
    logic [4:0]  e_idx;
    logic        e_mv;
    logic [15:0] e_merge;
    logic        e_done;
  } row_t;

  row_t tbl [8];

  always #5 sys_clk = ~sys_clk;

  qsn_ctrl_len17 #(.PIPE_DEPTH(0)) u_dut0 (
    .sys_clk(sys_clk), .rstn(rstn), .start(start), .col_num(col_num),
    .shift_factor(shift_factor), .shift_valid(shift_valid),
    .shift_ready(ready_v[0]), .left_sel(left_v[0]), .right_sel(right_v[0]),
    .shf_valid(shf_v[0]), .merge_sel(merge_v[0]), .merge_valid(mv_v[0]),
    .col_idx(idx_v[0]), .busy(busy_v[0]), .layer_done(done_v[0]),
    .factor_err(err_v[0]));

  qsn_ctrl_len17 #(.PIPE_DEPTH(1)) u_dut1 (
    .sys_clk(sys_clk), .rstn(rstn), .start(start), .col_num(col_num),
    .shift_factor(shift_factor), .shift_valid(shift_valid),
    .shift_ready(ready_v[1]), .left_sel(left_v[1]), .right_sel(right_v[1]),
    .shf_valid(shf_v[1]), .merge_sel(merge_v[1]), .merge_valid(mv_v[1]),
    .col_idx(idx_v[1]), .busy(busy_v[1]), .layer_done(done_v[1]),
    .factor_err(err_v[1]));

  qsn_ctrl_len17 #(.PIPE_DEPTH(3)) u_dut3 (
    .sys_clk(sys_clk), .rstn(rstn), .start(start), .col_num(col_num),
    .shift_factor(shift_factor), .shift_valid(shift_valid),
    .shift_ready(ready_v[2]), .left_sel(left_v[2]), .right_sel(right_v[2]),
    .shf_valid(shf_v[2]), .merge_sel(merge_v[2]), .merge_valid(mv_v[2]),
    .col_idx(idx_v[2]), .busy(busy_v[2]), .layer_done(done_v[2]),
    .factor_err(err_v[2]));

  function automatic int pdOf(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[pd=%0d] cycle %0d: got %0h expected %0h",
               name, pdOf(k), cyc, act, exp);
    end
  endtask

  // Compare every instance against the model for the current cycle
  task automatic checkOutput();
    for (int k = 0; k < 3; k++) begin
      if (m_in_layer[k] && m_cols_left[k] == 0 && cyc == m_done_cyc[k])
        m_in_layer[k] = 1'b0;
      check("busy", k, 32'(busy_v[k]), 32'(m_in_layer[k]));
      check("shift_ready", k, 32'(ready_v[k]),
            32'(m_in_layer[k] && m_cols_left[k] > 0));
      check("factor_err", k, 32'(err_v[k]), 32'(m_err[k]));
      check("shf_valid", k, 32'(shf_v[k]), 32'(e_shf[k][cyc]));
      if (e_shf[k][cyc]) begin
        check("left_sel", k, 32'(left_v[k]), 32'(e_left[k][cyc]));
        check("right_sel", k, 32'(right_v[k]), 32'(e_right[k][cyc]));
        check("col_idx", k, 32'(idx_v[k]), 32'(e_idx[k][cyc]));
      end
      check("merge_valid", k, 32'(mv_v[k]), 32'(e_mv[k][cyc]));
      if (e_mv[k][cyc])
        check("merge_sel", k, 32'(merge_v[k]), 32'(e_merge[k][cyc]));
      check("layer_done", k, 32'(done_v[k]), 32'(e_done[k][cyc]));
    end
  endtask

  // Drive one cycle of inputs, advance the model, then step the clock
  task automatic applyStimulus(input logic st, input logic [5:0] cn,
                               input logic sv, input logic [4:0] sf,
                               input logic rn);
    int l;
    logic [31:0] m;
    if (cyc + 8 >= NCYC) begin
      $display("[TB] FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NCYC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    start = st; col_num = cn; shift_valid = sv; shift_factor = sf; rstn = rn;
    for (int k = 0; k < 3; k++) begin
      if (!rn) begin
        m_in_layer[k] = 1'b0; m_err[k] = 1'b0; m_cols_left[k] = 0;
        for (int c = cyc + 1; c < cyc + 8; c++) begin
          e_shf[k][c] = 1'b0; e_mv[k][c] = 1'b0; e_done[k][c] = 1'b0;
        end
      end else if (!m_in_layer[k]) begin
        if (st) begin
          m_err[k] = 1'b0;
          if (cn == 0) e_done[k][cyc+1] = 1'b1;
          else begin
            m_in_layer[k]  = 1'b1;
            m_cols_left[k] = (int'(cn) > 32) ? 32 : int'(cn);
            m_next_idx[k]  = 0;
          end
        end
      end else if (m_cols_left[k] > 0 && sv) begin
        l = (int'(sf) < 17) ? int'(sf) : 0;
        if (int'(sf) >= 17) m_err[k] = 1'b1;
        e_shf[k][cyc+1]   = 1'b1;
        e_left[k][cyc+1]  = 5'(l);
        e_right[k][cyc+1] = 5'(16 - l);
        e_idx[k][cyc+1]   = 5'(m_next_idx[k]);
        m = (32'd1 << (16 - l)) - 32'd1;
        e_mv[k][cyc+1+pdOf(k)]    = 1'b1;
        e_merge[k][cyc+1+pdOf(k)] = m[15:0];
        m_next_idx[k]++;
        m_cols_left[k]--;
        if (m_cols_left[k] == 0) begin
          m_done_cyc[k] = cyc + pdOf(k) + 2;
          e_done[k][m_done_cyc[k]] = 1'b1;
        end
      end
    end
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
  endtask

  task automatic step(input logic st, input logic [5:0] cn, input logic sv,
                      input logic [4:0] sf, input logic rn);
    checkOutput();
    applyStimulus(st, cn, sv, sf, rn);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic checkZero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_ready"}, k, 32'(ready_v[k]), 0);
      check({tag, "_shf"},   k, 32'(shf_v[k]),   0);
      check({tag, "_mv"},    k, 32'(mv_v[k]),    0);
      check({tag, "_busy"},  k, 32'(busy_v[k]),  0);
      check({tag, "_done"},  k, 32'(done_v[k]),  0);
      check({tag, "_err"},   k, 32'(err_v[k]),   0);
      check({tag, "_left"},  k, 32'(left_v[k]),  0);
      check({tag, "_right"}, k, 32'(right_v[k]), 0);
      check({tag, "_merge"}, k, 32'(merge_v[k]), 0);
      check({tag, "_idx"},   k, 32'(idx_v[k]),   0);
    end
  endtask

  initial begin
    int n_shf;
    int seen_idx [4];
    int w;

    for (int k = 0; k < 3; k++) begin
      m_in_layer[k] = 0; m_cols_left[k] = 0; m_next_idx[k] = 0;
      m_done_cyc[k] = 0; m_err[k] = 0;
      for (int c = 0; c < NCYC; c++) begin
        e_shf[k][c] = 0; e_left[k][c] = 0; e_right[k][c] = 0; e_idx[k][c] = 0;
        e_mv[k][c] = 0; e_merge[k][c] = 0; e_done[k][c] = 0;
      end
    end

    // Basic layer at PIPE_DEPTH=1: factors 0, 5, 16
    //           st cn  sv sf  rdy bsy shf  L   R  idx mv  merge       done
    tbl[0] = '{1, 3, 0, 0,  0,  0,  0,  0,  0,  0,  0, 16'h0000, 0};
    tbl[1] = '{0, 0, 1, 0,  1,  1,  0,  0,  0,  0,  0, 16'h0000, 0};
    tbl[2] = '{0, 0, 1, 5,  1,  1,  1,  0, 16,  0,  0, 16'h0000, 0};
    tbl[3] = '{0, 0, 1, 16, 1,  1,  1,  5, 11,  1,  1, 16'hFFFF, 0};
    tbl[4] = '{0, 0, 0, 0,  0,  1,  1, 16,  0,  2,  1, 16'h07FF, 0};
    tbl[5] = '{0, 0, 0, 0,  0,  1,  0,  0,  0,  0,  1, 16'h0000, 0};
    tbl[6] = '{0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0, 16'h0000, 1};
    tbl[7] = '{0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0, 16'h0000, 0};

    start = 0; col_num = 0; shift_valid = 0; shift_factor = 0; rstn = 0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checkZero("por");
    rstn = 1;

    for (int r = 0; r < 8; r++) begin
      checkOutput();
      check("tbl_ready", 1, 32'(ready_v[1]), 32'(tbl[r].e_ready));
      check("tbl_busy",  1, 32'(busy_v[1]),  32'(tbl[r].e_busy));
      check("tbl_shf",   1, 32'(shf_v[1]),   32'(tbl[r].e_shf));
      if (tbl[r].e_shf) begin
        check("tbl_left",  1, 32'(left_v[1]),  32'(tbl[r].e_left));
        check("tbl_right", 1, 32'(right_v[1]), 32'(tbl[r].e_right));
        check("tbl_idx",   1, 32'(idx_v[1]),   32'(tbl[r].e_idx));
      end
      check("tbl_mv", 1, 32'(mv_v[1]), 32'(tbl[r].e_mv));
      if (tbl[r].e_mv) check("tbl_merge", 1, 32'(merge_v[1]), 32'(tbl[r].e_merge));
      check("tbl_done", 1, 32'(done_v[1]), 32'(tbl[r].e_done));
      applyStimulus(tbl[r].st, tbl[r].cn, tbl[r].sv, tbl[r].sf, 1'b1);
    end
    settle(4);

    // Bubbles: col_num=4 with shift_valid 1,0,1,1,0,1
    step(1'b1, 6'd4, 1'b0, 5'd0, 1'b1);
    n_shf = 0;
    for (int i = 0; i < 12; i++) begin
      logic v;
      v = (i < 6) ? ((6'b101101 >> i) & 6'd1) != 0 : 1'b0;
      if (shf_v[1]) begin
        if (n_shf < 4) seen_idx[n_shf] = int'(idx_v[1]);
        n_shf++;
      end
      step(1'b0, 6'd0, v, 5'(3 * i + 1), 1'b1);
    end
    check("bubble_count", 1, 32'(n_shf), 32'd4);
    for (int i = 0; i < 4; i++) check("bubble_idx", 1, 32'(seen_idx[i]), 32'(i));

    // Zero-length layer
    step(1'b1, 6'd0, 1'b0, 5'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("zero_done", k, 32'(done_v[k]), 1);
      check("zero_busy", k, 32'(busy_v[k]), 0);
    end
    settle(2);

    // Out-of-range factor in column 1
    step(1'b1, 6'd3, 1'b0, 5'd0, 1'b1);
    step(1'b0, 6'd0, 1'b1, 5'd4, 1'b1);
    step(1'b0, 6'd0, 1'b1, 5'd20, 1'b1);
    check("err_flag", 1, 32'(err_v[1]), 1);
    check("err_left", 1, 32'(left_v[1]), 0);
    step(1'b0, 6'd0, 1'b1, 5'd7, 1'b1);
    settle(8);
    check("err_sticky", 1, 32'(err_v[1]), 1);
    step(1'b1, 6'd2, 1'b0, 5'd0, 1'b1);
    for (int k = 0; k < 3; k++) check("err_clear", k, 32'(err_v[k]), 0);
    step(1'b0, 6'd0, 1'b1, 5'd1, 1'b1);
    step(1'b0, 6'd0, 1'b1, 5'd2, 1'b1);
    settle(8);

    // Reset held 3 cycles mid-RUN aborts without layer_done
    step(1'b1, 6'd8, 1'b0, 5'd0, 1'b1);
    step(1'b0, 6'd0, 1'b1, 5'd3, 1'b1);
    step(1'b0, 6'd0, 1'b1, 5'd9, 1'b1);
    step(1'b0, 6'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 6'd0, 1'b0, 5'd0, 1'b0);
    checkZero("rst");
    settle(10);

    // Overlap: start during RUN ignored, start in layer_done cycle accepted
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 6'd4, 1'b0, 5'd0, 1'b1);
      step(1'b0, 6'd0, 1'b1, 5'd2, 1'b1);
      step(1'b1, 6'd2, 1'b1, 5'd6, 1'b1);
      step(1'b0, 6'd0, 1'b1, 5'd11, 1'b1);
      step(1'b0, 6'd0, 1'b1, 5'd15, 1'b1);
      w = 0;
      while (w < 20 && !e_done[k][cyc]) begin
        step(1'b0, 6'd0, 1'b0, 5'd0, 1'b1);
        w++;
      end
      check("ovl_done_seen", k, 32'(e_done[k][cyc]), 1);
      check("ovl_done_dut", k, 32'(done_v[k]), 1);
      step(1'b1, 6'd2, 1'b0, 5'd0, 1'b1);
      check("ovl_restart_busy", k, 32'(busy_v[k]), 1);
      check("ovl_restart_ready", k, 32'(ready_v[k]), 1);
      step(1'b0, 6'd0, 1'b1, 5'd8, 1'b1);
      step(1'b0, 6'd0, 1'b1, 5'd12, 1'b1);
      settle(10);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       st, sv;
      logic [5:0] cn;
      logic [4:0] sf;
      st = ($urandom_range(0, 9) == 0);
      cn = 6'($urandom_range(0, 9));
      sv = ($urandom_range(0, 3) != 0);
      sf = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(17, 31))
                                        : 5'($urandom_range(0, 16));
      step(st, cn, sv, sf, 1'b1);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 6'd0, 1'b1, 5'($urandom_range(0, 16)), 1'b1);
    settle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
